// File: rtl/lsu_mem_port_pkg.sv
// Shared types for the load/store memory port: RV32I width codes, FSM encoding,
// the per-access context latched at request time, and the misalignment rule.
package lsu_mem_port_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] off;
    } lsu_req_t;

    // Only the defined halfword/word codes can be misaligned; LHU's code is undefined for stores.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off,
                                            input logic is_store);
        logic is_half;
        is_half = (f3 == LSU_H) || (!is_store && (f3 == LSU_HU));
        return (is_half && off[0]) || ((f3 == LSU_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Core-side and data-RAM-side signals of the load/store port in one bundle.
// master = the port itself, slave = the environment (core + RAM).
interface lsu_mem_port_if;

    logic        mem_rd;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lsu_stall;
    logic [31:0] lsu_rdata;
    logic        lsu_valid;
    logic        lsu_err;
    logic        dram_req;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [3:0]  dram_wmask;
    logic [31:0] dram_wdata;
    logic        dram_ack;
    logic [31:0] dram_rdata;

    modport master (
        input  mem_rd, mem_we, funct3, addr, wdata, dram_ack, dram_rdata,
        output lsu_stall, lsu_rdata, lsu_valid, lsu_err,
        output dram_req, dram_we, dram_addr, dram_wmask, dram_wdata
    );

    modport slave (
        output mem_rd, mem_we, funct3, addr, wdata, dram_ack, dram_rdata,
        input  lsu_stall, lsu_rdata, lsu_valid, lsu_err,
        input  dram_req, dram_we, dram_addr, dram_wmask, dram_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store mask/replication and load lane extraction with sign/zero extension.
// Purely combinational; undefined load codes read the full word, undefined store codes write no lanes.
module lsu_align
    import lsu_mem_port_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wmask     = 4'b0000;
        wdata_rep = st_data;
        case (funct3)
            LSU_B: begin
                wmask     = 4'b0001 << off;
                wdata_rep = {4{st_data[7:0]}};
            end
            LSU_H: begin
                wmask     = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{st_data[15:0]}};
            end
            LSU_W:   wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    always_comb begin
        case (off)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = off[1] ? ld_word[31:16] : ld_word[15:0];
    end

    always_comb begin
        case (funct3)
            LSU_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LSU_BU:  ld_data = {24'd0, ld_byte};
            LSU_H:   ld_data = {{16{ld_half[15]}}, ld_half};
            LSU_HU:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port between the core's memory stage and a variable-latency req/ack data RAM.
// Stalls the core until retirement; optional LSU_MISALIGN_TRAP_EN retires misaligned accesses with lsu_err.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic           cpu_clk,
    input  logic           cpu_rst,
    lsu_mem_port_if.master bus
);

    lsu_state_t    state, state_nxt;
    lsu_req_t      req_q;
    logic [TW-1:0] cnt;

    logic          start;
    logic          is_store;
    logic          timeout_hit;
    logic          misalign;

    logic [2:0]    al_f3;
    logic [1:0]    al_off;
    logic [3:0]    al_wmask;
    logic [31:0]   al_wdata;
    logic [31:0]   al_ldata;

    logic          dram_req_q;
    logic          dram_we_q;
    logic [31:0]   dram_addr_q;
    logic [3:0]    dram_wmask_q;
    logic [31:0]   dram_wdata_q;
    logic [31:0]   lsu_rdata_q;
    logic          lsu_valid_q;
    logic          lsu_err_q;

    assign start       = bus.mem_rd | bus.mem_we;
    assign is_store    = bus.mem_we;
    assign timeout_hit = (cnt == TW'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = lsu_misaligned(bus.funct3, bus.addr[1:0], is_store);
`else
    assign misalign = 1'b0;
`endif

    // One aligner serves both directions: live inputs while forming a request, latched context while waiting.
    assign al_f3  = (state == IDLE) ? bus.funct3      : req_q.funct3;
    assign al_off = (state == IDLE) ? bus.addr[1:0]   : req_q.off;

    lsu_align u_align (
        .funct3    (al_f3),
        .off       (al_off),
        .st_data   (bus.wdata),
        .ld_word   (bus.dram_rdata),
        .wmask     (al_wmask),
        .wdata_rep (al_wdata),
        .ld_data   (al_ldata)
    );

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = misalign ? DONE : REQ;
            REQ:     if (bus.dram_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            req_q        <= '0;
            cnt          <= '0;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wmask_q <= '0;
            dram_wdata_q <= '0;
            lsu_rdata_q  <= '0;
            lsu_valid_q  <= 1'b0;
            lsu_err_q    <= 1'b0;
        end else begin
            lsu_valid_q <= 1'b0;
            lsu_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        req_q        <= '{is_store: is_store, funct3: bus.funct3, off: bus.addr[1:0]};
                        cnt          <= '0;
                        dram_we_q    <= is_store;
                        dram_addr_q  <= {bus.addr[31:2], 2'b00};
                        dram_wmask_q <= is_store ? al_wmask : 4'b0000;
                        dram_wdata_q <= is_store ? al_wdata : 32'd0;
                        if (misalign) begin
                            dram_req_q  <= 1'b0;
                            lsu_valid_q <= 1'b1;
                            lsu_err_q   <= 1'b1;
                            if (!is_store) lsu_rdata_q <= '0;
                        end else begin
                            dram_req_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.dram_ack) begin
                        dram_req_q  <= 1'b0;
                        lsu_valid_q <= 1'b1;
                        if (!req_q.is_store) lsu_rdata_q <= al_ldata;
                    end else if (timeout_hit) begin
                        dram_req_q  <= 1'b0;
                        lsu_valid_q <= 1'b1;
                        lsu_err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Stall drops in DONE so the core advances exactly as the access retires.
    assign bus.lsu_stall  = ((state == IDLE) && start) || (state == REQ);
    assign bus.lsu_rdata  = lsu_rdata_q;
    assign bus.lsu_valid  = lsu_valid_q;
    assign bus.lsu_err    = lsu_err_q;
    assign bus.dram_req   = dram_req_q;
    assign bus.dram_we    = dram_we_q;
    assign bus.dram_addr  = dram_addr_q;
    assign bus.dram_wmask = dram_wmask_q;
    assign bus.dram_wdata = dram_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed vector table, random accesses against a lane-arithmetic model, reset mid-access.
// Honours LSU_MISALIGN_TRAP_EN when the design is built with it.
module tb_lsu_mem_port;

    localparam int TIMEOUT = 16;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        string       name;
        bit          st;
        bit          both;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          noreq;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    string cur_name = "";
    logic [31:0] last_rdata;
    vec_t tbl[$];

    lsu_mem_port_if bus ();

    lsu_mem_port #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %h expected %h", cur_name, name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 4'(1 << a[1:0]);
            3'd1:    return a[1] ? 4'b1100 : 4'b0011;
            3'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'd0:    return wd[7:0] * 32'h0101_0101;
            3'd1:    return wd[15:0] * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit model_mis(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit half;
        half = (f3 == 3'd1) || (!st && f3 == 3'd5);
        return (half && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
    endfunction

    // Drives one access from IDLE and follows it until the cycle after its valid pulse.
    task automatic run_access(input vec_t v);
        int          req_cycles;
        int          exp_cycles;
        bit          stall_bad;
        bit          stable_bad;
        logic [31:0] a0;
        logic [3:0]  m0;
        cur_name = v.name;
        bus.mem_rd = !v.st || v.both;
        bus.mem_we = v.st;
        bus.funct3 = v.f3;
        bus.addr   = v.addr;
        bus.wdata  = v.wdata;
        #1;
        chk("stall_idle", 32'(bus.lsu_stall), 32'd1);
        @(posedge clk); #1;
        if (!v.noreq) begin
            chk("dram_addr", bus.dram_addr, v.addr & ~32'h3);
            chk("dram_we", 32'(bus.dram_we), 32'(v.st));
            if (v.st) chk("dram_wmask", 32'(bus.dram_wmask), 32'(v.exp_mask));
            if (v.st && v.exp_mask != 4'd0) chk("dram_wdata", bus.dram_wdata, v.exp_wdata);
        end
        a0 = bus.dram_addr;
        m0 = bus.dram_wmask;
        req_cycles = 0;
        stall_bad  = 1'b0;
        stable_bad = 1'b0;
        while (bus.dram_req && req_cycles < TIMEOUT + 4) begin
            if (!bus.lsu_stall) stall_bad = 1'b1;
            if (bus.dram_addr !== a0 || bus.dram_wmask !== m0) stable_bad = 1'b1;
            if (req_cycles == v.delay) begin
                bus.dram_ack   = 1'b1;
                bus.dram_rdata = v.rdata;
            end
            @(posedge clk); #1;
            bus.dram_ack   = 1'b0;
            bus.dram_rdata = $urandom;
            req_cycles++;
        end
        exp_cycles = v.noreq ? 0 : ((v.delay < TIMEOUT) ? v.delay + 1 : TIMEOUT);
        chk("req_cycles", 32'(req_cycles), 32'(exp_cycles));
        if (!v.noreq) begin
            chk("stall_in_req", 32'(stall_bad), 32'd0);
            chk("req_stable", 32'(stable_bad), 32'd0);
        end
        chk("valid", 32'(bus.lsu_valid), 32'd1);
        chk("err", 32'(bus.lsu_err), 32'(v.exp_err));
        chk("stall_done", 32'(bus.lsu_stall), 32'd0);
        chk("rdata", bus.lsu_rdata, v.exp_rdata);
        bus.mem_rd = 1'b0;
        bus.mem_we = 1'b0;
        @(posedge clk); #1;
        chk("valid_pulse", 32'(bus.lsu_valid), 32'd0);
        last_rdata = v.exp_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k;
        int   nv;
        bus.mem_rd = 1'b0; bus.mem_we = 1'b0; bus.funct3 = '0;
        bus.addr = '0; bus.wdata = '0; bus.dram_ack = 1'b0; bus.dram_rdata = '0;

        tbl.push_back(vec_t'{"sw",       1,0,3'b010,32'h100,32'hDEADBEEF,32'h0,       2,4'b1111,32'hDEADBEEF,32'h00000000,0,0});
        tbl.push_back(vec_t'{"lw",       0,0,3'b010,32'h100,32'h0,       32'hDEADBEEF,0,4'b0000,32'h0,       32'hDEADBEEF,0,0});
        tbl.push_back(vec_t'{"lb",       0,0,3'b000,32'h103,32'h0,       32'h80FF1234,1,4'b0000,32'h0,       32'hFFFFFF80,0,0});
        tbl.push_back(vec_t'{"lbu",      0,0,3'b100,32'h103,32'h0,       32'h80FF1234,1,4'b0000,32'h0,       32'h00000080,0,0});
        tbl.push_back(vec_t'{"lhu",      0,0,3'b101,32'h102,32'h0,       32'h80FF1234,0,4'b0000,32'h0,       32'h000080FF,0,0});
        tbl.push_back(vec_t'{"lh",       0,0,3'b001,32'h102,32'h0,       32'h80FF1234,2,4'b0000,32'h0,       32'hFFFF80FF,0,0});
        tbl.push_back(vec_t'{"sb",       1,0,3'b000,32'h201,32'h000000A5,32'h0,       3,4'b0010,32'hA5A5A5A5,32'hFFFF80FF,0,0});
        tbl.push_back(vec_t'{"sh",       1,0,3'b001,32'h206,32'h1234BEEF,32'h0,       1,4'b1100,32'hBEEFBEEF,32'hFFFF80FF,0,0});
        tbl.push_back(vec_t'{"lb_pos",   0,0,3'b000,32'h101,32'h0,       32'h00007F00,0,4'b0000,32'h0,       32'h0000007F,0,0});
        tbl.push_back(vec_t'{"timeout",  0,0,3'b010,32'h300,32'h0,       32'h11111111,TIMEOUT,4'b0000,32'h0, 32'h0000007F,1,0});
        tbl.push_back(vec_t'{"ld_undef", 0,0,3'b011,32'h010,32'h0,       32'h12345678,1,4'b0000,32'h0,       32'h12345678,0,0});
        tbl.push_back(vec_t'{"ack_last", 0,0,3'b010,32'h600,32'h0,       32'h55AA55AA,TIMEOUT-1,4'b0000,32'h0,32'h55AA55AA,0,0});
        tbl.push_back(vec_t'{"st_undef", 1,0,3'b011,32'h020,32'h99999999,32'h0,       0,4'b0000,32'h0,       32'h55AA55AA,0,0});
        tbl.push_back(vec_t'{"both",     1,1,3'b010,32'h400,32'h11223344,32'h0,       1,4'b1111,32'h11223344,32'h55AA55AA,0,0});
`ifdef LSU_MISALIGN_TRAP_EN
        tbl.push_back(vec_t'{"lw_mis",   0,0,3'b010,32'h102,32'h0,       32'hCAFEF00D,0,4'b0000,32'h0,       32'h00000000,1,1});
`else
        tbl.push_back(vec_t'{"lw_mis",   0,0,3'b010,32'h102,32'h0,       32'hCAFEF00D,0,4'b0000,32'h0,       32'hCAFEF00D,0,0});
`endif

        cur_name = "reset";
        repeat (2) @(posedge clk);
        #1;
        chk("dram_req", 32'(bus.dram_req), 32'd0);
        chk("dram_we", 32'(bus.dram_we), 32'd0);
        chk("dram_addr", bus.dram_addr, 32'd0);
        chk("dram_wmask", 32'(bus.dram_wmask), 32'd0);
        chk("dram_wdata", bus.dram_wdata, 32'd0);
        chk("lsu_rdata", bus.lsu_rdata, 32'd0);
        chk("lsu_valid", 32'(bus.lsu_valid), 32'd0);
        chk("lsu_err", 32'(bus.lsu_err), 32'd0);
        chk("lsu_stall", 32'(bus.lsu_stall), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        last_rdata = 32'd0;

        for (int i = 0; i < tbl.size(); i++) run_access(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 6);
            v.name  = "rand";
            v.st    = 1'($urandom_range(0, 1));
            v.both  = v.st && ($urandom_range(0, 3) == 0);
            case (k)
                0: v.f3 = 3'd0;
                1: v.f3 = 3'd1;
                2: v.f3 = 3'd2;
                3: v.f3 = 3'd4;
                4: v.f3 = 3'd5;
                5: v.f3 = 3'd3;
                default: v.f3 = 3'd6;
            endcase
            v.addr  = $urandom;
            if (!(v.f3 inside {3'd0, 3'd1, 3'd2}) && (v.st || !(v.f3 inside {3'd4, 3'd5})))
                v.addr[1:0] = 2'd0;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.delay = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
            v.noreq = TRAP && model_mis(v.st, v.f3, v.addr);
            v.exp_err   = v.noreq || (v.delay >= TIMEOUT);
            v.exp_mask  = v.st ? model_mask(v.f3, v.addr) : 4'd0;
            v.exp_wdata = model_wdata(v.f3, v.wdata);
            if (v.st)                    v.exp_rdata = last_rdata;
            else if (v.noreq)            v.exp_rdata = 32'd0;
            else if (v.delay >= TIMEOUT) v.exp_rdata = last_rdata;
            else                         v.exp_rdata = model_load(v.f3, v.addr, v.rdata);
            run_access(v);
        end

        cur_name = "rst_mid";
        bus.mem_rd = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h500;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("req_before_rst", 32'(bus.dram_req), 32'd1);
        rst = 1'b1;
        bus.mem_rd = 1'b0;
        #1;
        chk("req_drop", 32'(bus.dram_req), 32'd0);
        chk("stall_drop", 32'(bus.lsu_stall), 32'd0);
        nv = 0;
        repeat (2) begin @(posedge clk); #1; nv += int'(bus.lsu_valid); end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; nv += int'(bus.lsu_valid); end
        chk("no_valid", 32'(nv), 32'd0);
        chk("req_idle", 32'(bus.dram_req), 32'd0);
        chk("rdata_cleared", bus.lsu_rdata, 32'd0);
        last_rdata = 32'd0;
        run_access(vec_t'{"lw_after_rst",0,0,3'b010,32'h104,32'h0,32'h0BADF00D,1,4'b0000,32'h0,32'h0BADF00D,0,0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
